// File: rtl/eprisc_io_pkg.sv
// Shared definitions for the epRISC I/O controller: register map, STATUS bit
// positions and the serial state encoding.
package eprisc_io_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_RXDATA  = 3'd1;
    localparam logic [2:0] REG_TXDATA  = 3'd2;
    localparam logic [2:0] REG_CONTROL = 3'd3;
    localparam logic [2:0] REG_ID      = 3'd4;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_FRAMING   = 2;
    localparam int ST_TX_BUSY   = 3;
    localparam int ST_FULL      = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} serial_state_t;

endpackage

// File: rtl/eprisc_uart_rx.sv
// 8N1 UART receiver: input synchronizer, start/data/stop state machine and
// bit timing. Emits a one-cycle valid or framing-error strobe per frame.
module eprisc_uart_rx
    import eprisc_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    serial_state_t state, state_n;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          valid_n, err_n;

    // NOTE: every register below is sequential state, so it is written with <= only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shift     <= shift_n;
            valid     <= valid_n;
            frame_err <= err_n;
        end
    end

    // NOTE: all outputs of this block get a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        shift_n = shift;
        valid_n = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_sync) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    valid_n = rx_sync;
                    err_n   = !rx_sync;
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            valid_n = 1'b0;
            err_n   = 1'b0;
        end
    end

    assign data = shift;

endmodule

// File: rtl/eprisc_io_controller.sv
// epRISC I/O controller: byte-wide bus slave with a register file, RX FIFO,
// UART transmitter and an RX-pending interrupt.
module eprisc_io_controller
    import eprisc_io_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 256,
    parameter int          RX_DEPTH     = 4,
    parameter logic [7:0]  DEVICE_ID    = 8'hE5
) (
    input  logic       iBoardClock,
    input  logic       iBoardReset,
    input  logic       oBusClock,
    input  logic [1:0] oBusSelect,
    input  logic [7:0] oBusMOSI,
    output logic [7:0] iBusMISO,
    output logic       iBusInterrupt,
    input  logic       iTTLSerialRX,
    input  logic       iTTLSerialRST,
    output logic       oTTLSerialTX
);

    localparam int PW = $clog2(RX_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FIFO_MAX = (PW + 1)'(RX_DEPTH);

    // Bus framing
    logic       bus_clk_q, selected, bus_rise, edge2;
    logic [1:0] edge_cnt;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic       wr_strobe, rd_strobe, status_rd;

    // Registers, FIFO, TX
    logic [7:0] control, status, rd_data;
    logic       overrun, ferr;
    logic [7:0] fifo_mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic       empty, full, push, pop;
    logic       tx_busy, tx_line, tx_load;
    logic [CW-1:0] tx_cnt;
    logic [3:0] tx_bit;
    logic [8:0] tx_frame;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err;

    eprisc_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (iBoardClock),
        .rst_n    (iBoardReset),
        .flush    (iTTLSerialRST),
        .rx       (iTTLSerialRX),
        .data     (rx_data),
        .valid    (rx_valid),
        .frame_err(rx_err)
    );

    assign selected  = (oBusSelect == 2'b01);
    assign bus_rise  = oBusClock && !bus_clk_q;
    assign edge2     = selected && bus_rise && (edge_cnt == 2'd1);
    assign wr_strobe = edge2 && cmd_write;
    assign rd_strobe = edge2 && !cmd_write;
    assign status_rd = rd_strobe && (cmd_addr == REG_STATUS);

    assign empty   = (count == '0);
    assign full    = (count == FIFO_MAX);
    assign pop     = rd_strobe && (cmd_addr == REG_RXDATA) && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push    = rx_valid && (!full || pop);
    assign tx_load = wr_strobe && (cmd_addr == REG_TXDATA) && !tx_busy;

    always_ff @(posedge iBoardClock) begin
        if (!iBoardReset) begin
            bus_clk_q <= 1'b0;
            edge_cnt  <= '0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
        end else begin
            bus_clk_q <= oBusClock;
            if (!selected) begin
                edge_cnt <= '0;
            end else if (bus_rise && edge_cnt != 2'd2) begin
                edge_cnt <= edge_cnt + 2'd1;
                if (edge_cnt == 2'd0) begin
                    cmd_write <= oBusMOSI[7];
                    cmd_addr  <= oBusMOSI[2:0];
                end
            end
        end
    end

    always_comb begin
        status               = '0;
        status[ST_NOT_EMPTY] = !empty;
        status[ST_OVERRUN]   = overrun;
        status[ST_FRAMING]   = ferr;
        status[ST_TX_BUSY]   = tx_busy;
        status[ST_FULL]      = full;
    end

    always_comb begin
        rd_data = '0;
        case (cmd_addr)
            REG_STATUS:  rd_data = status;
            REG_RXDATA:  rd_data = empty ? 8'h00 : fifo_mem[rd_ptr];
            REG_CONTROL: rd_data = control;
            REG_ID:      rd_data = DEVICE_ID;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge iBoardClock) begin
        if (!iBoardReset) begin
            control       <= '0;
            overrun       <= 1'b0;
            ferr          <= 1'b0;
            iBusMISO      <= '0;
            iBusInterrupt <= 1'b0;
        end else begin
            if (wr_strobe && cmd_addr == REG_CONTROL) control <= oBusMOSI;
            if (rd_strobe) iBusMISO <= rd_data;
            // A set arriving with the clearing STATUS read wins so no event is lost.
            if (status_rd) begin
                overrun <= 1'b0;
                ferr    <= 1'b0;
            end
            if (rx_valid && full && !pop) overrun <= 1'b1;
            if (rx_err) ferr <= 1'b1;
            iBusInterrupt <= control[0] && !empty;
        end
    end

    always_ff @(posedge iBoardClock) begin
        if (!iBoardReset || iTTLSerialRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count define validity.
    always_ff @(posedge iBoardClock) begin
        if (push) fifo_mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge iBoardClock) begin
        if (!iBoardReset || iTTLSerialRST) begin
            tx_busy  <= 1'b0;
            tx_line  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_frame <= '0;
        end else if (tx_load) begin
            tx_busy  <= 1'b1;
            tx_line  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_frame <= {1'b1, oBusMOSI};
        end else if (tx_busy) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx_bit   <= tx_bit + 4'd1;
                    tx_line  <= tx_frame[0];
                    tx_frame <= {1'b0, tx_frame[8:1]};
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    assign oTTLSerialTX = tx_line;

endmodule

// File: tb/tb_eprisc_io_controller.sv
// Self-checking bench for eprisc_io_controller: register-map vector table,
// read scoreboard, and serial RX/TX/flush/reset sequences.
module tb_eprisc_io_controller;

    localparam int CPB = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bus_clk = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [7:0] mosi = 8'h00;
    logic       rx = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] miso;
    logic       irq;
    logic       tx;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    eprisc_io_controller #(
        .CLKS_PER_BIT(CPB),
        .RX_DEPTH    (4),
        .DEVICE_ID   (8'hE5)
    ) dut (
        .iBoardClock  (clk),
        .iBoardReset  (rst_n),
        .oBusClock    (bus_clk),
        .oBusSelect   (sel),
        .oBusMOSI     (mosi),
        .iBusMISO     (miso),
        .iBusInterrupt(irq),
        .iTTLSerialRX (rx),
        .iTTLSerialRST(flush),
        .oTTLSerialTX (tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full two-edge bus transaction; reads are scored against the queue head.
    task automatic bus_txn(input logic wr, input logic [2:0] addr, input logic [7:0] data,
                           input logic [7:0] exp, input string name);
        logic [7:0] e;
        if (!wr) exp_q.push_back(exp);
        @(negedge clk);
        sel  = 2'b01;
        mosi = {wr, 4'b0000, addr};
        wait_clk(2);
        bus_clk = 1'b1;
        wait_clk(2);
        bus_clk = 1'b0;
        mosi    = data;
        wait_clk(2);
        bus_clk = 1'b1;
        wait_clk(2);
        if (!wr) begin
            e = exp_q.pop_front();
            check(name, miso, e);
        end
        bus_clk = 1'b0;
        sel     = 2'b00;
        wait_clk(2);
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [7:0] exp, input string name);
        bus_txn(1'b0, addr, 8'h00, exp, name);
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [7:0] data);
        bus_txn(1'b1, addr, data, 8'h00, "write");
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            wait_clk(CPB);
        end
        rx = 1'b1;
        wait_clk(4);
    endtask

    task automatic tx_monitor(input logic [7:0] data);
        logic [9:0] frame;
        int n;
        frame = {1'b1, data, 1'b0};
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_seen", (n < 200), 1);
        wait_clk(CPB / 2);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), tx, frame[i]);
            if (i < 9) wait_clk(CPB);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'd4, 8'h00, 8'hE5};
        vecs[1]  = '{1'b0, 3'd0, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 3'd3, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 3'd3, 8'h5A, 8'h00};
        vecs[4]  = '{1'b0, 3'd3, 8'h00, 8'h5A};
        vecs[5]  = '{1'b0, 3'd1, 8'h00, 8'h00};
        vecs[6]  = '{1'b1, 3'd6, 8'hFF, 8'h00};
        vecs[7]  = '{1'b0, 3'd6, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 3'd4, 8'h12, 8'h00};
        vecs[9]  = '{1'b0, 3'd4, 8'h00, 8'hE5};
        vecs[10] = '{1'b1, 3'd3, 8'h00, 8'h00};

        rst_n = 1'b0;
        wait_clk(24);
        rst_n = 1'b1;
        wait_clk(2);
        check("reset_tx", tx, 1);
        check("reset_miso", miso, 8'h00);
        check("reset_irq", irq, 0);

        for (int i = 0; i < 11; i++)
            bus_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));

        // Deselect after the command edge aborts the write; a lone edge later is a new edge 1.
        @(negedge clk);
        sel = 2'b01; mosi = 8'h83;
        wait_clk(2); bus_clk = 1'b1; wait_clk(2); bus_clk = 1'b0;
        sel = 2'b00; wait_clk(2);
        sel = 2'b01; mosi = 8'hAA;
        wait_clk(2); bus_clk = 1'b1; wait_clk(2); bus_clk = 1'b0;
        sel = 2'b00; wait_clk(2);
        bus_read(3'd3, 8'h00, "abort_ctrl");

        // RX and interrupt
        bus_write(3'd3, 8'h01);
        check("irq_idle", irq, 0);
        send_byte(8'h31, 1'b1);
        check("irq_after_rx", irq, 1);
        send_byte(8'h0D, 1'b1);
        bus_read(3'd1, 8'h31, "rx_byte0");
        check("irq_one_left", irq, 1);
        bus_read(3'd1, 8'h0D, "rx_byte1");
        check("irq_drained", irq, 0);
        bus_write(3'd3, 8'h00);

        // TX frame with busy status and a dropped second write
        fork
            tx_monitor(8'hA5);
            begin
                bus_write(3'd2, 8'hA5);
                bus_read(3'd0, 8'h08, "tx_busy_status");
                bus_write(3'd2, 8'hFF);
            end
        join
        wait_clk(CPB / 2 + 4);
        bus_read(3'd0, 8'h00, "tx_done_status");
        check("tx_idle_line", tx, 1);

        // Overrun: five bytes into a four-deep FIFO
        for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i), 1'b1);
        bus_read(3'd0, 8'h13, "overrun_status");
        bus_read(3'd0, 8'h11, "overrun_cleared");
        for (int i = 0; i < 4; i++) bus_read(3'd1, 8'h41 + 8'(i), $sformatf("drain%0d", i));
        bus_read(3'd0, 8'h00, "drained_status");

        // Framing error, then a short glitch
        send_byte(8'h55, 1'b0);
        bus_read(3'd0, 8'h04, "framing_status");
        bus_read(3'd0, 8'h00, "framing_cleared");
        rx = 1'b0;
        wait_clk(64);
        rx = 1'b1;
        wait_clk(11 * CPB);
        bus_read(3'd0, 8'h00, "glitch_status");

        // Flush with queued bytes and TX busy
        bus_write(3'd3, 8'h01);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        bus_write(3'd2, 8'h3C);
        bus_read(3'd0, 8'h09, "pre_flush_status");
        check("pre_flush_irq", irq, 1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_tx", tx, 1);
        wait_clk(1);
        check("flush_irq", irq, 0);
        bus_read(3'd0, 8'h00, "flush_status");
        bus_read(3'd1, 8'h00, "flush_rxdata");
        bus_read(3'd3, 8'h01, "flush_ctrl_kept");

        // Reset in the middle of a TX frame
        bus_write(3'd2, 8'h00);
        wait_clk(3 * CPB);
        check("tx_low_midframe", tx, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_tx", tx, 1);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        check("reset_miso_again", miso, 8'h00);
        bus_read(3'd3, 8'h00, "reset_ctrl");
        bus_read(3'd0, 8'h00, "reset_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
